// File: rtl/lcd_pkg.sv
// Shared definitions for the panel init sequencer and the drawing stages.
// Build option: LCD_INVERSION_EN adds the INVON step before DISPON.
package lcd_pkg;

  // Panel command opcodes
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_INVON   = 8'h21;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

`ifdef LCD_INVERSION_EN
  localparam int NUM_STEPS = 8;
`else
  localparam int NUM_STEPS = 7;
`endif
  localparam int STEP_W = 3;
  localparam int CNT_W  = 22;

  typedef enum logic [2:0] {
    S_IDLE, S_HW_LOW, S_HW_WAIT, S_LOAD, S_TX, S_DELAY, S_DONE
  } state_t;

  // Which settle delay (if any) follows a step
  typedef enum logic [1:0] {
    DLY_NONE, DLY_SWRESET, DLY_SLPOUT
  } dly_t;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
    dly_t       dly;
  } step_t;

  // Only the two parameter bytes (COLMOD value, MADCTL value) go out with dc=1
  function automatic logic step_dc(input logic [STEP_W-1:0] idx);
    return (idx == 3'd3) || (idx == 3'd5);
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// 8-bit MSB-first SPI shifter clocked directly by i_clk.
// i_we at cycle t: o_cs low with bits 7..0 on t+1..t+8, o_cs high and o_done at t+9.
module spi_byte_tx (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic [7:0] i_byte,
  output logic       o_mosi,
  output logic       o_cs,
  output logic       o_done
);

  logic [6:0] r_sh;
  logic [2:0] r_left;
  logic       r_mosi;
  logic       r_cs;
  logic       r_done;

  // Load on i_we when idle, then shift one bit per cycle; mosi parks low between bytes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh   <= '0;
      r_left <= '0;
      r_mosi <= 1'b0;
      r_cs   <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_cs) begin
        if (r_left == 3'd0) begin
          r_cs   <= 1'b1;
          r_mosi <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_mosi <= r_sh[6];
          r_sh   <= {r_sh[5:0], 1'b0};
          r_left <= r_left - 3'd1;
        end
      end else if (i_we) begin
        r_cs   <= 1'b0;
        r_mosi <= i_byte[7];
        r_sh   <= i_byte[6:0];
        r_left <= 3'd7;
      end
    end
  end

  assign o_mosi = r_mosi;
  assign o_cs   = r_cs;
  assign o_done = r_done;

endmodule

// File: rtl/lcd_init_seq.sv
// Power-up init sequencer for the SPI TFT panel: hardware reset pulse, then
// SWRESET, SLPOUT, COLMOD, MADCTL, [INVON], DISPON with settle delays.
// Build option: define LCD_INVERSION_EN to insert INVON (0x21) before DISPON.
module lcd_init_seq
  import lcd_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_LOW      = 22'd270_000,
  parameter logic [CNT_W-1:0] RST_WAIT     = 22'd3_240_000,
  parameter logic [CNT_W-1:0] SWRESET_WAIT = 22'd3_240_000,
  parameter logic [CNT_W-1:0] SLPOUT_WAIT  = 22'd3_240_000,
  parameter logic [7:0]       COLMOD_VAL   = 8'h55,
  parameter logic [7:0]       MADCTL_VAL   = 8'h00
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  output logic o_mosi,
  output logic o_dc,
  output logic o_cs,
  output logic o_lcd_rst_n,
  output logic o_busy,
  output logic o_done
);

  state_t             r_state;
  logic [STEP_W-1:0]  r_step;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dc;
  logic               r_busy;
  logic               r_done;
  logic               r_lcd_rst_n;

  step_t              w_cur;
  logic [STEP_W-1:0]  w_nxt_idx;
  logic               w_last;
  logic [CNT_W-1:0]   w_dly;
  logic               w_we;
  logic               w_tx_done;

  // Command/parameter list
  function automatic step_t step_at(input logic [STEP_W-1:0] idx);
    step_t s;
    s = '{dc: step_dc(idx), data: CMD_DISPON, dly: DLY_NONE};
    case (idx)
      3'd0: begin s.data = CMD_SWRESET; s.dly = DLY_SWRESET; end
      3'd1: begin s.data = CMD_SLPOUT;  s.dly = DLY_SLPOUT;  end
      3'd2: s.data = CMD_COLMOD;
      3'd3: s.data = COLMOD_VAL;
      3'd4: s.data = CMD_MADCTL;
      3'd5: s.data = MADCTL_VAL;
`ifdef LCD_INVERSION_EN
      3'd6: s.data = CMD_INVON;
`endif
      default: s.data = CMD_DISPON;
    endcase
    return s;
  endfunction

  // Current step entry and its delay length
  always_comb begin
    w_cur     = step_at(r_step);
    w_nxt_idx = r_step + 3'd1;
    w_last    = (r_step == STEP_W'(NUM_STEPS - 1));
    w_we      = (r_state == S_LOAD);
    w_dly     = 22'd1;
    case (w_cur.dly)
      DLY_SWRESET: w_dly = SWRESET_WAIT;
      DLY_SLPOUT:  w_dly = SLPOUT_WAIT;
      default:     w_dly = 22'd1;
    endcase
  end

  // Sequencer; dc is updated on entry to LOAD so it only moves while cs is high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_step      <= '0;
      r_cnt       <= '0;
      r_dc        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_lcd_rst_n <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state     <= S_HW_LOW;
            r_busy      <= 1'b1;
            r_lcd_rst_n <= 1'b0;
            r_cnt       <= RST_LOW - 22'd1;
            r_step      <= '0;
            r_dc        <= 1'b0;
          end
        end
        S_HW_LOW: begin
          if (r_cnt == '0) begin
            r_state     <= S_HW_WAIT;
            r_lcd_rst_n <= 1'b1;
            r_cnt       <= RST_WAIT - 22'd1;
          end else begin
            r_cnt <= r_cnt - 22'd1;
          end
        end
        S_HW_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_LOAD;
            r_dc    <= w_cur.dc;
          end else begin
            r_cnt <= r_cnt - 22'd1;
          end
        end
        S_LOAD: r_state <= S_TX;
        S_TX: begin
          if (w_tx_done) begin
            if (w_cur.dly != DLY_NONE) begin
              r_state <= S_DELAY;
              r_cnt   <= w_dly - 22'd1;
            end else if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_LOAD;
              r_step  <= w_nxt_idx;
              r_dc    <= step_dc(w_nxt_idx);
            end
          end
        end
        S_DELAY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 22'd1;
          end else if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_LOAD;
            r_step  <= w_nxt_idx;
            r_dc    <= step_dc(w_nxt_idx);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  spi_byte_tx u_tx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_we),
    .i_byte  (w_cur.data),
    .o_mosi  (o_mosi),
    .o_cs    (o_cs),
    .o_done  (w_tx_done)
  );

  assign o_dc        = r_dc;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_lcd_rst_n = r_lcd_rst_n;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Directed bench for lcd_init_seq with all delays set to 4 cycles.
module tb_lcd_init_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic o_mosi, o_dc, o_cs, o_lcd_rst_n, o_busy, o_done;

  lcd_init_seq #(
    .RST_LOW(22'd4), .RST_WAIT(22'd4), .SWRESET_WAIT(22'd4), .SLPOUT_WAIT(22'd4),
    .COLMOD_VAL(8'h55), .MADCTL_VAL(8'h00)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_mosi(o_mosi), .o_dc(o_dc), .o_cs(o_cs), .o_lcd_rst_n(o_lcd_rst_n),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dc;
    logic [7:0] b;
  } vec_t;

  typedef struct {
    logic       dc;
    logic [7:0] b;
    int         w;
  } cap_t;

  vec_t exp_tbl[$];
  cap_t cap_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // byte monitor state
  int         m_bits = 0;
  int         m_high = 99;
  logic       m_dc = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         gap_viol = 0;
  int         dc_viol = 0;
  int         mosi_viol = 0;
  int         last_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture each cs-low window as one byte, checking framing rules along the way
  always @(negedge clk) begin
    if (!rst_n) begin
      m_bits = 0;
      m_high = 99;
    end else if (o_cs == 1'b0) begin
      if (m_bits == 0) begin
        m_dc = o_dc;
        if (m_high < 2) gap_viol++;
      end else if (o_dc !== m_dc) begin
        dc_viol++;
      end
      m_byte = {m_byte[6:0], o_mosi};
      m_bits++;
      m_high = 0;
    end else begin
      if (o_mosi !== 1'b0) mosi_viol++;
      if (m_bits != 0) begin
        cap_q.push_back('{dc: m_dc, b: m_byte, w: m_bits});
        last_rise = cyc;
        m_bits = 0;
      end
      m_high++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int at);
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk("done_seen", {31'd0, o_done}, 32'd1);
    at = cyc;
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_count"}, cap_q.size(), exp_tbl.size());
    for (int i = 0; i < exp_tbl.size() && i < cap_q.size(); i++) begin
      chk($sformatf("%s_dc%0d", tag, i), {31'd0, cap_q[i].dc}, {31'd0, exp_tbl[i].dc});
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, cap_q[i].b}, {24'd0, exp_tbl[i].b});
      chk($sformatf("%s_width%0d", tag, i), cap_q[i].w, 8);
    end
  endtask

  initial begin
    int n, at;
    exp_tbl.push_back('{1'b0, 8'h01});
    exp_tbl.push_back('{1'b0, 8'h11});
    exp_tbl.push_back('{1'b0, 8'h3A});
    exp_tbl.push_back('{1'b1, 8'h55});
    exp_tbl.push_back('{1'b0, 8'h36});
    exp_tbl.push_back('{1'b1, 8'h00});
`ifdef LCD_INVERSION_EN
    exp_tbl.push_back('{1'b0, 8'h21});
`endif
    exp_tbl.push_back('{1'b0, 8'h29});

    // reset values
    tick(); tick();
    chk("rst_mosi", {31'd0, o_mosi}, 32'd0);
    chk("rst_dc", {31'd0, o_dc}, 32'd0);
    chk("rst_cs", {31'd0, o_cs}, 32'd1);
    chk("rst_lcd_rst_n", {31'd0, o_lcd_rst_n}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_busy", {31'd0, o_busy}, 32'd0);

    // full run: hardware reset pulse width and first byte position
    cap_q.delete();
    pulse_start();
    chk("start_busy", {31'd0, o_busy}, 32'd1);
    chk("start_lcd_rst", {31'd0, o_lcd_rst_n}, 32'd0);
    n = 0;
    while (o_lcd_rst_n === 1'b0 && n < 100) begin n++; tick(); end
    chk("hw_low_cycles", n, 4);
    n = 0;
    while (o_cs === 1'b1 && n < 100) begin n++; tick(); end
    chk("hw_wait_to_cs", n, 5);
    wait_done(2000, at);
    chk("done_busy", {31'd0, o_busy}, 32'd0);
    chk("done_latency", at - last_rise, 1);
    tick();
    chk("done_one_cycle", {31'd0, o_done}, 32'd0);
    chk("idle_after_run", {31'd0, o_lcd_rst_n}, 32'd1);
    compare_stream("run1");
    chk("gap_viol", gap_viol, 0);
    chk("dc_viol", dc_viol, 0);
    chk("mosi_viol", mosi_viol, 0);

    // reset asserted during step 3, bit 4
    cap_q.delete();
    pulse_start();
    n = 0;
    while (!(cap_q.size() == 3 && o_cs === 1'b0 && m_bits == 3) && n < 2000) begin tick(); n++; end
    chk("midrst_reached", {31'd0, n < 2000}, 32'd1);
    chk("midrst_dc_param", {31'd0, o_dc}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs", {31'd0, o_cs}, 32'd1);
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_lcd_rst", {31'd0, o_lcd_rst_n}, 32'd1);
    chk("midrst_mosi", {31'd0, o_mosi}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("midrst_idle", {31'd0, o_busy}, 32'd0);
    cap_q.delete();
    pulse_start();
    chk("replay_lcd_rst", {31'd0, o_lcd_rst_n}, 32'd0);
    wait_done(2000, at);
    tick();
    compare_stream("replay");

    // start held high: mid-run level ignored, restart right after done
    cap_q.delete();
    start = 1'b1;
    tick();
    chk("hold_busy", {31'd0, o_busy}, 32'd1);
    wait_done(2000, at);
    compare_stream("hold");
    tick();
    chk("hold_idle_busy", {31'd0, o_busy}, 32'd0);
    chk("hold_idle_rst", {31'd0, o_lcd_rst_n}, 32'd1);
    tick();
    chk("hold_restart_busy", {31'd0, o_busy}, 32'd1);
    chk("hold_restart_rst", {31'd0, o_lcd_rst_n}, 32'd0);
    start = 1'b0;
    chk("gap_viol_end", gap_viol, 0);
    chk("dc_viol_end", dc_viol, 0);
    chk("mosi_viol_end", mosi_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_init_seq.md
# lcd_init_seq

Power-up initialisation sequencer for the SPI TFT panel; sits directly upstream of the picture/fill drawing stage. On a start request it pulses the panel's hardware reset, then streams the fixed command/parameter list with the required settle delays: SWRESET, SLPOUT, COLMOD, MADCTL, optional INVON, DISPON. It ends with a one-cycle `o_done`, which the top level wires to the drawing stage's `i_start`. The top level muxes `o_mosi`/`o_dc`/`o_cs` between this block and the drawing stage using `o_busy`.

## Interface
- `RST_LOW`, 270_000: cycles `o_lcd_rst_n` is held low (10 ms at 27 MHz).
- `RST_WAIT`, 3_240_000: cycles to wait after releasing `o_lcd_rst_n`.
- `SWRESET_WAIT`, 3_240_000: cycles to wait after the SWRESET byte.
- `SLPOUT_WAIT`, 3_240_000: cycles to wait after the SLPOUT byte.
- `COLMOD_VAL`, 8'h55: COLMOD parameter (RGB565).
- `MADCTL_VAL`, 8'h00: MADCTL parameter.
- `i_clk`  in  1  system clock; the SPI bit clock is `i_clk` itself.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  level; sampled only in IDLE.
- `o_mosi`  out  1  serial data, MSB first.
- `o_dc`  out  1  0 = command byte, 1 = parameter byte.
- `o_cs`  out  1  active-low chip select.
- `o_lcd_rst_n`  out  1  panel hardware reset, active low.
- `o_busy`  out  1  high from leaving IDLE until DONE.
- `o_done`  out  1  one-cycle pulse when the sequence completes.

## Operation
- Reset values: `o_mosi`=0, `o_dc`=0, `o_cs`=1, `o_lcd_rst_n`=1, `o_busy`=0, `o_done`=0; state=IDLE, step=0.
- States and transitions:
  - IDLE: `i_start`=1 → HW_LOW.
  - HW_LOW: `o_lcd_rst_n`=0 for RST_LOW cycles → HW_WAIT.
  - HW_WAIT: `o_lcd_rst_n`=1 for RST_WAIT cycles → LOAD.
  - LOAD: drive the step's `dc` and byte, pulse the transmitter `we` → TX.
  - TX: wait for the transmitter `done`. If the step has a delay → DELAY; else if last step → DONE; else step+1 → LOAD.
  - DELAY: count the step's delay → next step, or DONE after the last step.
  - DONE: `o_done`=1 for one cycle, `o_busy`=0 → IDLE.
- Step table (dc, byte, delay):
  - 0: cmd 0x01, SWRESET_WAIT
  - 1: cmd 0x11, SLPOUT_WAIT
  - 2: cmd 0x3A, none
  - 3: data COLMOD_VAL, none
  - 4: cmd 0x36, none
  - 5: data MADCTL_VAL, none
  - [cmd 0x21, none — only with the macro]
  - last: cmd 0x29, none
- A single 22-bit down-counter serves all delays. Every delay parameter must be ≥1 and <2^22; a value of 1 gives exactly one DELAY cycle.
- `i_start` is ignored while busy. If `i_start` is still high when the block returns to IDLE, the sequence restarts on the next cycle.
- Reset asserted mid-sequence: all outputs take their reset values immediately, with no partial byte completion; the sequence starts again from HW_LOW on the next start.

## Timing
- `i_start` high in IDLE at cycle 0 → `o_busy`=1 and `o_lcd_rst_n`=0 at cycle 1.
- Byte transmit: `we` at cycle t → `o_cs`=0 with bits 7..0 on cycles t+1..t+8 → `o_cs`=1 and transmitter `done` at t+9.
- Byte-to-byte period is 10 cycles: `o_cs` low for 8, high for 2.
- `o_dc` changes only while `o_cs`=1, and is stable for the whole byte.
- `o_mosi`=0 whenever `o_cs`=1.
- After the last byte's `done` at cycle d, `o_done` is high at d+1.

## Configuration
- `LCD_INVERSION_EN` defined: step "cmd 0x21 (INVON)" is inserted before DISPON, giving 8 steps and 80 data-phase byte cycles.
- `LCD_INVERSION_EN` undefined: 7 steps, and 0x21 never appears on `o_mosi`.

## Structure
- Shared package `lcd_pkg` holds:
  - command opcodes: SWRESET 0x01, SLPOUT 0x11, COLMOD 0x3A, MADCTL 0x36, INVON 0x21, DISPON 0x29, and CASET 0x2A / PASET 0x2B / RAMWR 0x2C for the drawing stages;
  - the state encoding;
  - the step count, derived from the macro.
- Sub-module `spi_byte_tx`: 8-bit MSB-first shifter with `i_we`/`i_byte` → `o_mosi`/`o_cs`/`o_done`, same clock and reset.
- The step table is a combinational case on the step index.

## Test plan
All delay parameters are set to 4 for simulation.
- Reset release, then `i_start` pulse → `o_lcd_rst_n` low for exactly 4 cycles. First `o_cs` falling edge comes after the HW_WAIT count; the captured byte is 0x01 with `o_dc`=0.
- Full run, macro undefined → captured stream (dc:byte) is 0:01, 0:11, 0:3A, 1:55, 0:36, 1:00, 0:29, then a single `o_done` pulse and `o_busy`=0.
- Macro defined → stream is identical except 0:21 appears between 1:00 and 0:29.
- Byte framing → each `o_cs` low window is exactly 8 cycles, with at least 2 high cycles between bytes. `o_dc` never toggles while `o_cs`=0.
- `i_rst_n` asserted during step 3, bit 4 → the same cycle shows `o_cs`=1, `o_busy`=0, `o_lcd_rst_n`=1. A new `i_start` replays from HW_LOW.
- `i_start` held high throughout → extra pulses are ignored mid-run, and the sequence restarts the cycle after the `o_done` pulse.
